// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between instruction fetch
// and load/store. Data accesses win ties, except when fetch has already been
// passed over STARVE_LIMIT times in a row. One access is in flight at a time:
// IDLE -> ISSUE_x -> RESP -> IDLE. All outputs come straight from registers.
module mem_port_arbiter #(
  parameter int AW           = 8,
  parameter int DW           = 16,
  parameter int STARVE_LIMIT = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_done,
  output logic [DW-1:0] if_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_done,
  output logic [DW-1:0] d_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ready,
  output logic          busy
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE_I, S_ISSUE_D, S_RESP} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_I, OWN_D} owner_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t        r_state;
  owner_t        r_last_owner;
  logic [3:0]    r_streak;
  logic          r_if_done;
  logic          r_d_done;
  logic [DW-1:0] r_if_rdata;
  logic [DW-1:0] r_d_rdata;
  logic          r_mem_en;
  logic          r_mem_we;
  logic [AW-1:0] r_mem_addr;
  logic [DW-1:0] r_mem_wdata;
  logic          r_busy;

  logic          w_grant_d;
  logic          w_grant_i;
  logic [3:0]    w_streak_next;

  // Arbitration decision and streak update for a data grant in IDLE.
  always_comb begin
    // NOTE: every combinational output gets a value before any branch, so no
    // path can leave it unassigned and infer a latch.
    w_grant_d     = 1'b0;
    w_grant_i     = 1'b0;
    w_streak_next = r_streak;
    w_grant_d     = d_req && !(if_req && (r_streak == LIMIT));
    w_grant_i     = if_req && !w_grant_d;
    // Only data grants that made fetch wait extend the streak.
    if (!if_req) begin
      w_streak_next = 4'd0;
    end else if (r_streak != LIMIT) begin
      w_streak_next = r_streak + 4'd1;
    end
  end

  // Access FSM with registered memory-side and requester-side outputs.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    if (!reset) begin
      r_state      <= S_IDLE;
      r_last_owner <= OWN_NONE;
      r_streak     <= 4'd0;
      r_if_done    <= 1'b0;
      r_d_done     <= 1'b0;
      r_if_rdata   <= '0;
      r_d_rdata    <= '0;
      r_mem_en     <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_busy       <= 1'b0;
    end else begin
      // Done strobes are single-cycle: they drop unless re-armed below.
      r_if_done <= 1'b0;
      r_d_done  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_grant_d) begin
            r_state      <= S_ISSUE_D;
            r_last_owner <= OWN_D;
            r_streak     <= w_streak_next;
            r_mem_en     <= 1'b1;
            r_mem_we     <= d_we;
            r_mem_addr   <= d_addr;
            r_mem_wdata  <= d_wdata;
            r_busy       <= 1'b1;
          end else if (w_grant_i) begin
            r_state      <= S_ISSUE_I;
            r_last_owner <= OWN_I;
            r_streak     <= 4'd0;
            r_mem_en     <= 1'b1;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= if_addr;
            r_mem_wdata  <= '0;
            r_busy       <= 1'b1;
          end
        end
        S_ISSUE_I, S_ISSUE_D: begin
          // mem_* hold their grant-time values until the memory answers.
          if (mem_ready) begin
            r_state  <= S_RESP;
            r_mem_en <= 1'b0;
            r_mem_we <= 1'b0;
            if (r_last_owner == OWN_I) begin
              r_if_rdata <= mem_rdata;
              r_if_done  <= 1'b1;
            end else begin
              if (!r_mem_we) begin
                r_d_rdata <= mem_rdata;
              end
              r_d_done <= 1'b1;
            end
          end
        end
        S_RESP: begin
          // Requesters see done here; a held request is arbitrated in IDLE.
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign if_done   = r_if_done;
  assign d_done    = r_d_done;
  assign if_rdata  = r_if_rdata;
  assign d_rdata   = r_d_rdata;
  assign mem_en    = r_mem_en;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign busy      = r_busy;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed reset/abort/starvation sequences,
// a table of single transactions, and randomized traffic against a
// transaction-level reference model with a behavioural memory.
module tb_mem_port_arbiter;

  localparam int AW    = 8;
  localparam int DW    = 16;
  localparam int LIMIT = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_done;
  logic [DW-1:0] if_rdata;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_done;
  logic [DW-1:0] d_rdata;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ready;
  logic          busy;

  mem_port_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(LIMIT)) dut (
    .clk       (clk),
    .reset     (reset),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_done   (if_done),
    .if_rdata  (if_rdata),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_done    (d_done),
    .d_rdata   (d_rdata),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Memory responder configuration.
  int            wait_cfg   = 0;
  bit            rand_waits = 1'b0;
  bit            noise      = 1'b0;
  bit            use_array  = 1'b0;
  logic [DW-1:0] cfg_rdata  = '0;
  logic [DW-1:0] mem_model [256];

  typedef struct {
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    int            waits;
    logic [DW-1:0] rdata;
    logic          exp_d;
    logic [AW-1:0] exp_addr;
    logic          exp_we;
    logic [DW-1:0] exp_wdata;
    logic [DW-1:0] exp_if_rdata;
    logic [DW-1:0] exp_d_rdata;
    int            exp_lat;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [60:0] all_out();
    return {if_done, d_done, if_rdata, d_rdata, mem_en, mem_we, mem_addr, mem_wdata, busy};
  endfunction

  task automatic drive_idle();
    if_req  = 1'b0;
    d_req   = 1'b0;
    d_we    = 1'b0;
    if_addr = '0;
    d_addr  = '0;
    d_wdata = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    drive_idle();
    repeat (2) @(negedge clk);
    check("reset_outputs", all_out(), 64'd0);
    reset = 1'b1;
  endtask

  // Memory model: answers after the configured number of wait states.
  initial begin
    int en_cycles;
    int cur_waits;
    en_cycles = 0;
    cur_waits = 0;
    forever begin
      @(posedge clk);
      #1;
      if (mem_en) begin
        en_cycles++;
        if (en_cycles == 1) cur_waits = rand_waits ? int'($urandom_range(0, 3)) : wait_cfg;
        if (en_cycles == cur_waits + 1) begin
          mem_ready = 1'b1;
          mem_rdata = use_array ? mem_model[mem_addr] : cfg_rdata;
          if (mem_we) mem_model[mem_addr] = mem_wdata;
        end else begin
          mem_ready = 1'b0;
          mem_rdata = 16'($urandom);
        end
      end else begin
        en_cycles = 0;
        mem_ready = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        mem_rdata = 16'($urandom);
      end
    end
  end

  // One table transaction from an idle arbiter, then a check of the idle cycle.
  task automatic run_vec(input int idx, input vec_t v);
    int            en_cnt;
    int            lat;
    bit            got;
    bit            which_d;
    bit            unstable;
    logic [AW-1:0] a;
    logic          w;
    logic [DW-1:0] wd;
    en_cnt = 0; lat = 0; got = 1'b0; which_d = 1'b0; unstable = 1'b0;
    a = '0; w = 1'b0; wd = '0;
    wait_cfg  = v.waits;
    cfg_rdata = v.rdata;
    @(negedge clk);
    if_req = v.if_req; if_addr = v.if_addr;
    d_req = v.d_req; d_we = v.d_we; d_addr = v.d_addr; d_wdata = v.d_wdata;
    for (int c = 1; c <= 40 && !got; c++) begin
      @(negedge clk);
      if (mem_en) begin
        if (en_cnt == 0) begin
          a = mem_addr; w = mem_we; wd = mem_wdata;
        end else if ({mem_addr, mem_we, mem_wdata} != {a, w, wd}) begin
          unstable = 1'b1;
        end
        en_cnt++;
      end
      if (if_done || d_done) begin
        got = 1'b1;
        lat = c;
        which_d = d_done;
        check($sformatf("v%0d_one_done", idx), if_done && d_done, 0);
        check($sformatf("v%0d_resp_busy", idx), {busy, mem_en}, 2'b10);
      end
    end
    check($sformatf("v%0d_done_seen", idx), got, 1);
    if (got) begin
      check($sformatf("v%0d_winner", idx), which_d, v.exp_d);
      check($sformatf("v%0d_addr", idx), a, v.exp_addr);
      check($sformatf("v%0d_we", idx), w, v.exp_we);
      check($sformatf("v%0d_wdata", idx), wd, v.exp_wdata);
      check($sformatf("v%0d_stable", idx), unstable, 0);
      check($sformatf("v%0d_en_cycles", idx), en_cnt, v.waits + 1);
      check($sformatf("v%0d_latency", idx), lat, v.exp_lat);
      check($sformatf("v%0d_if_rdata", idx), if_rdata, v.exp_if_rdata);
      check($sformatf("v%0d_d_rdata", idx), d_rdata, v.exp_d_rdata);
    end
    drive_idle();
    @(negedge clk);
    check($sformatf("v%0d_idle", idx), {mem_en, busy, if_done, d_done}, 4'b0000);
    check($sformatf("v%0d_hold", idx), {if_rdata, d_rdata}, {v.exp_if_rdata, v.exp_d_rdata});
  endtask

  initial begin
    int            n;
    int            first_c;
    logic [7:0]    starve_pat;
    bit            if_pend, d_pend, open, resp_now, exp_grant, exp_done_next;
    bit            win_d, own_d, g_if_req, g_we, idle;
    logic [AW-1:0] g_addr;
    logic [DW-1:0] g_wdata, exp_rd, m_if, m_d;
    int            streak_m;

    // {if_req,if_addr, d_req,d_we,d_addr,d_wdata, waits,rdata,
    //  exp_d,exp_addr,exp_we,exp_wdata, exp_if_rdata,exp_d_rdata, exp_lat}
    vecs[0] = '{1'b1, 8'h10, 1'b0, 1'b0, 8'h00, 16'h0000, 0, 16'hBEEF,
                1'b0, 8'h10, 1'b0, 16'h0000, 16'hBEEF, 16'h0000, 2};
    vecs[1] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h22, 16'h1234, 3, 16'hDEAD,
                1'b1, 8'h22, 1'b1, 16'h1234, 16'hBEEF, 16'h0000, 5};
    vecs[2] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h33, 16'h0000, 1, 16'hA5A5,
                1'b1, 8'h33, 1'b0, 16'h0000, 16'hBEEF, 16'hA5A5, 3};
    vecs[3] = '{1'b1, 8'h44, 1'b1, 1'b0, 8'h55, 16'h9999, 0, 16'h0F0F,
                1'b1, 8'h55, 1'b0, 16'h9999, 16'hBEEF, 16'h0F0F, 2};
    vecs[4] = '{1'b1, 8'hFF, 1'b0, 1'b0, 8'h00, 16'h0000, 2, 16'h1357,
                1'b0, 8'hFF, 1'b0, 16'h0000, 16'h1357, 16'h0F0F, 4};
    vecs[5] = '{1'b1, 8'h60, 1'b1, 1'b1, 8'h00, 16'hFFFF, 0, 16'hDEAD,
                1'b1, 8'h00, 1'b1, 16'hFFFF, 16'h1357, 16'h0F0F, 2};
    vecs[6] = '{1'b1, 8'h61, 1'b1, 1'b0, 8'h01, 16'h0000, 0, 16'h2468,
                1'b1, 8'h01, 1'b0, 16'h0000, 16'h1357, 16'h2468, 2};
    vecs[7] = '{1'b1, 8'h62, 1'b1, 1'b1, 8'h02, 16'h5555, 1, 16'hDEAD,
                1'b1, 8'h02, 1'b1, 16'h5555, 16'h1357, 16'h2468, 3};
    vecs[8] = '{1'b1, 8'h80, 1'b1, 1'b1, 8'h03, 16'h7777, 0, 16'hCAFE,
                1'b0, 8'h80, 1'b0, 16'h0000, 16'hCAFE, 16'h2468, 2};
    vecs[9] = '{1'b0, 8'h81, 1'b1, 1'b0, 8'h7F, 16'h0000, 0, 16'h0001,
                1'b1, 8'h7F, 1'b0, 16'h0000, 16'hCAFE, 16'h0001, 2};

    for (int i = 0; i < 256; i++) mem_model[i] = 16'($urandom);
    mem_ready = 1'b0;
    mem_rdata = '0;

    // Reset held with both requests pending: nothing may be granted.
    reset = 1'b0;
    if_req = 1'b1; if_addr = 8'h05;
    d_req = 1'b1; d_we = 1'b0; d_addr = 8'h06; d_wdata = 16'h0000;
    wait_cfg = 10;
    repeat (2) begin
      @(negedge clk);
      check("reset_hold", all_out(), 64'd0);
    end
    reset = 1'b1;
    @(negedge clk);
    check("first_grant", {mem_en, mem_we, mem_addr, busy}, {1'b1, 1'b0, 8'h06, 1'b1});

    // Abort the data access mid-flight.
    @(negedge clk);
    check("no_early_done", {if_done, d_done}, 2'b00);
    reset = 1'b0;
    @(negedge clk);
    check("abort_outputs", all_out(), 64'd0);
    wait_cfg = 0;
    reset = 1'b1;

    // Both requests held: D,D,D,I,D,D,D,I (also shows the streak was cleared).
    starve_pat = 8'b0111_0111;
    n = 0;
    for (int c = 0; c < 100 && n < 8; c++) begin
      @(negedge clk);
      if (if_done || d_done) begin
        check($sformatf("starve_%0d", n), d_done, starve_pat[n]);
        n++;
      end
    end
    check("starve_count", n, 8);
    drive_idle();

    do_reset();
    for (int i = 0; i < 10; i++) run_vec(i, vecs[i]);

    // Simultaneous requests; data drops after its done, fetch follows.
    @(negedge clk);
    cfg_rdata = 16'h4242;
    wait_cfg  = 0;
    if_req = 1'b1; if_addr = 8'hA0;
    d_req = 1'b1; d_we = 1'b0; d_addr = 8'hB0;
    n = 0;
    first_c = 0;
    for (int c = 1; c <= 30 && n < 2; c++) begin
      @(negedge clk);
      if (mem_en) check($sformatf("simul_addr_%0d", n), mem_addr, (n == 0) ? 8'hB0 : 8'hA0);
      if (if_done || d_done) begin
        if (n == 0) begin
          check("simul_first_d", {if_done, d_done}, 2'b01);
          d_req = 1'b0;
          first_c = c;
        end else begin
          check("simul_second_i", {if_done, d_done}, 2'b10);
          check("simul_gap", c - first_c, 3);
          check("simul_if_rdata", if_rdata, 16'h4242);
        end
        n++;
      end
    end
    check("simul_count", n, 2);
    drive_idle();

    // Randomized traffic against a transaction-level model.
    rand_waits = 1'b1;
    noise      = 1'b1;
    use_array  = 1'b1;
    do_reset();
    if_pend = 0; d_pend = 0; open = 0; resp_now = 0; exp_grant = 0; exp_done_next = 0;
    win_d = 0; own_d = 0; g_if_req = 0; g_we = 0; idle = 0;
    g_addr = '0; g_wdata = '0; exp_rd = '0; m_if = '0; m_d = '0; streak_m = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      if (exp_grant) begin
        open  = 1'b1;
        own_d = win_d;
        check("rnd_addr", mem_addr, g_addr);
        check("rnd_we", mem_we, g_we);
        check("rnd_wdata", mem_wdata, g_wdata);
        exp_rd = mem_model[g_addr];
        if (win_d && g_if_req) streak_m = (streak_m < LIMIT) ? streak_m + 1 : streak_m;
        else streak_m = 0;
      end
      resp_now = exp_done_next;
      if (resp_now) begin
        if (!own_d) m_if = exp_rd;
        else if (!g_we) m_d = exp_rd;
      end
      check("rnd_done", {if_done, d_done}, resp_now ? (own_d ? 2'b01 : 2'b10) : 2'b00);
      check("rnd_mem_en", mem_en, open);
      check("rnd_busy", busy, open || resp_now);
      check("rnd_if_rdata", if_rdata, m_if);
      check("rnd_d_rdata", d_rdata, m_d);
      idle = !open && !resp_now;
      exp_done_next = open && mem_ready;
      if (exp_done_next) open = 1'b0;

      if (resp_now) begin
        if (own_d) d_pend = 1'b0;
        else if_pend = 1'b0;
      end
      if (!if_pend) begin
        if ($urandom_range(0, 2) == 0) begin
          if_pend = 1'b1;
          if_addr = 8'($urandom_range(0, 15));
        end else begin
          if_addr = 8'($urandom);
        end
      end
      if (!d_pend) begin
        d_pend  = ($urandom_range(0, 2) == 0);
        d_addr  = d_pend ? 8'($urandom_range(0, 15)) : 8'($urandom);
        d_we    = 1'($urandom);
        d_wdata = 16'($urandom);
      end
      if_req = if_pend;
      d_req  = d_pend;

      exp_grant = idle && (if_req || d_req);
      if (exp_grant) begin
        win_d    = d_req && !(if_req && (streak_m == LIMIT));
        g_if_req = if_req;
        g_addr   = win_d ? d_addr : if_addr;
        g_we     = win_d ? d_we : 1'b0;
        g_wdata  = win_d ? d_wdata : 16'h0000;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
